pixel_row_serializer: RTL

Sits directly downstream of the pixel array readout. Accepts one complete row of `PIXEL_BITS`-wide pixels per handshake and buffers up to `ROW_DEPTH` rows. It streams each row out over an `OUTPUT_BUS_WIDTH`-pixel bus, tagging every beat with row/chunk indices and frame markers. All parameter defaults come from the `PixelSensorConfig` package.

---
 rtl/pixel_row_serializer_pkg.sv | 32 +++
 rtl/pixel_row_serializer_if.sv | 46 ++++
 rtl/pixel_row_serializer_fifo.sv | 70 +++++++
 rtl/pixel_row_serializer.sv | 108 ++++++++++
 4 files changed

// File: rtl/pixel_row_serializer_pkg.sv
// ============================================================================
//  Module      : PixelSensorConfig (package)
//  Description : Sensor geometry defaults, derived index widths and pixel
//                container types shared by the row serializer and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package PixelSensorConfig;

    localparam int PIXEL_ARRAY_HEIGHT = 128;
    localparam int PIXEL_ARRAY_WIDTH  = 128;
    localparam int PIXEL_BITS         = 8;
    localparam int OUTPUT_BUS_WIDTH   = 8;
    localparam int ROW_DEPTH          = 2;

    localparam int CHUNKS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int ROW_IDX_BITS   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int CHUNK_IDX_BITS = $clog2(CHUNKS_PER_ROW);

    typedef logic [PIXEL_BITS-1:0]         pixel_t;
    typedef pixel_t [PIXEL_ARRAY_WIDTH-1:0] pixel_row_t;
    typedef pixel_t [OUTPUT_BUS_WIDTH-1:0]  pixel_beat_t;

    // Pointer width that stays legal for a single-entry buffer
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_row_serializer_if.sv
// ============================================================================
//  Module      : pixel_row_serializer_if
//  Description : Row-in / beat-out handshake bundle of the row serializer.
//                slave = serializer view, master = producer/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_row_serializer_if #(
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
    parameter int OUTPUT_BUS_WIDTH   = PixelSensorConfig::OUTPUT_BUS_WIDTH
);
    localparam int ROW_W       = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int BEAT_W      = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int ROW_IDX_W   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int CHUNK_IDX_W = $clog2(PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH);

    logic                   row_valid;
    logic                   row_ready;
    logic [ROW_W-1:0]       row_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [BEAT_W-1:0]      out_data;
    logic [ROW_IDX_W-1:0]   out_row;
    logic [CHUNK_IDX_W-1:0] out_chunk;
    logic                   out_sof;
    logic                   out_eol;
    logic                   out_eof;

    modport slave (
        input  row_valid, row_data, out_ready,
        output row_ready, out_valid, out_data, out_row, out_chunk,
               out_sof, out_eol, out_eof
    );

    modport master (
        output row_valid, row_data, out_ready,
        input  row_ready, out_valid, out_data, out_row, out_chunk,
               out_sof, out_eol, out_eof
    );

endinterface

`default_nettype wire

// File: rtl/pixel_row_serializer_fifo.sv
// ============================================================================
//  Module      : pixel_row_fifo
//  Description : DEPTH-entry buffer of whole pixel rows plus their row tags.
//                Storage is not reset; only pointers and occupancy are.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_row_fifo
    import PixelSensorConfig::*;
#(
    parameter int DEPTH = PixelSensorConfig::ROW_DEPTH,
    parameter int ROW_W = PixelSensorConfig::PIXEL_ARRAY_WIDTH * PixelSensorConfig::PIXEL_BITS,
    parameter int TAG_W = PixelSensorConfig::ROW_IDX_BITS
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             wr_en,     // caller guarantees !full
    input  wire logic [ROW_W-1:0] wr_data,
    input  wire logic [TAG_W-1:0] wr_tag,
    input  wire logic             rd_en,     // caller guarantees !empty
    output logic      [ROW_W-1:0] rd_data,
    output logic      [TAG_W-1:0] rd_tag,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ROW_W-1:0] r_mem     [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Row and tag storage; deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr]     <= wr_data;
            r_tag_mem[r_wr_ptr] <= wr_tag;
        end
    end

    // Wrapping pointers and occupancy; a same-cycle write and free cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (rd_en)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign rd_tag  = r_tag_mem[r_rd_ptr];
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pixel_row_serializer.sv
// ============================================================================
//  Module      : pixel_row_serializer
//  Description : Buffers whole pixel rows and streams each one out as
//                OUTPUT_BUS_WIDTH-pixel beats tagged with row/chunk indices
//                and start-of-frame / end-of-line / end-of-frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_row_serializer #(
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
    parameter int OUTPUT_BUS_WIDTH   = PixelSensorConfig::OUTPUT_BUS_WIDTH,
    parameter int ROW_DEPTH          = PixelSensorConfig::ROW_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pixel_row_serializer_if.slave  bus
);
    localparam int ROW_W       = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int BEAT_W      = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int CHUNKS      = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int ROW_IDX_W   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int CHUNK_IDX_W = $clog2(CHUNKS);

    generate
        if (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH != 0) begin : g_bad_bus_width
            $error("PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
        end
        if (ROW_DEPTH < 1) begin : g_bad_depth
            $error("ROW_DEPTH must be at least 1");
        end
    endgenerate

    logic                   w_full;
    logic                   w_empty;
    logic                   w_out_valid;
    logic                   w_wr_en;
    logic                   w_beat;
    logic                   w_last_chunk;
    logic                   w_rd_en;
    logic [ROW_W-1:0]       w_rd_data;
    logic [ROW_IDX_W-1:0]   w_rd_tag;
    logic [BEAT_W-1:0]      w_beat_data;
    logic [ROW_IDX_W-1:0]   r_in_row;
    logic [CHUNK_IDX_W-1:0] r_chunk;

    assign w_out_valid  = !w_empty;
    assign w_wr_en      = bus.row_valid && !w_full;
    assign w_beat       = w_out_valid && bus.out_ready;
    assign w_last_chunk = (r_chunk == CHUNK_IDX_W'(CHUNKS - 1));
    assign w_rd_en      = w_beat && w_last_chunk;   // row is freed with its last beat
    assign w_beat_data  = w_rd_data[r_chunk * BEAT_W +: BEAT_W];

    pixel_row_fifo #(
        .DEPTH (ROW_DEPTH),
        .ROW_W (ROW_W),
        .TAG_W (ROW_IDX_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_data (bus.row_data),
        .wr_tag  (r_in_row),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .rd_tag  (w_rd_tag),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Input row tag and output chunk position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_row <= '0;
            r_chunk  <= '0;
        end else begin
            if (w_wr_en)
                r_in_row <= (r_in_row == ROW_IDX_W'(PIXEL_ARRAY_HEIGHT - 1)) ? '0 : r_in_row + 1'b1;
            if (w_beat)
                r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
        end
    end

    // Beat fields and markers, all decoded from registers and zeroed when idle
    always_comb begin
        bus.row_ready = !w_full;
        bus.out_valid = w_out_valid;
        bus.out_data  = '0;
        bus.out_row   = '0;
        bus.out_chunk = '0;
        bus.out_sof   = 1'b0;
        bus.out_eol   = 1'b0;
        bus.out_eof   = 1'b0;
        if (w_out_valid) begin
            bus.out_data  = w_beat_data;
            bus.out_row   = w_rd_tag;
            bus.out_chunk = r_chunk;
            bus.out_sof   = (w_rd_tag == '0) && (r_chunk == '0);
            bus.out_eol   = w_last_chunk;
            bus.out_eof   = w_last_chunk && (w_rd_tag == ROW_IDX_W'(PIXEL_ARRAY_HEIGHT - 1));
        end
    end

endmodule

`default_nettype wire
